// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked multi-cycle 64-bit data memory responder
// Optional macro MISALIGN_TRAP_EN: flag misaligned accesses instead of aligning the lane down.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [2:0]        lat_size;
  logic [IDX_W+2:0]  lat_addr;
  logic [63:0]       lat_wdata;
  logic [63:0]       mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [2:0]        width_m1;
  logic [7:0]        base_mask;
  logic [2:0]        lane;
  logic [7:0]        byte_en;
  logic [63:0]       word;
  logic [63:0]       shifted;
  logic [63:0]       wdata_sh;
  logic [63:0]       merged;
  logic [63:0]       load_val;
  logic              access_err;
  logic              access;
  logic              mem_we;

  // Address bits above the storage window alias and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr[63:IDX_W+3];

  always_comb begin
    idx = lat_addr[IDX_W+2:3];
    width_m1 = 3'd0;
    base_mask = 8'h01;
    case (lat_size[1:0])
      2'd0: begin width_m1 = 3'd0; base_mask = 8'h01; end
      2'd1: begin width_m1 = 3'd1; base_mask = 8'h03; end
      2'd2: begin width_m1 = 3'd3; base_mask = 8'h0F; end
      default: begin width_m1 = 3'd7; base_mask = 8'hFF; end
    endcase
    lane = lat_addr[2:0] & ~width_m1;
    byte_en = base_mask << lane;
    word = mem[idx];
    shifted = word >> {lane, 3'b000};
    wdata_sh = lat_wdata << {lane, 3'b000};
    for (int i = 0; i < 8; i++) begin
      merged[8*i +: 8] = byte_en[i] ? wdata_sh[8*i +: 8] : word[8*i +: 8];
    end
    load_val = shifted;
    case (lat_size)
      3'b000: load_val = {{56{shifted[7]}}, shifted[7:0]};
      3'b001: load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010: load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b100: load_val = {56'd0, shifted[7:0]};
      3'b101: load_val = {48'd0, shifted[15:0]};
      3'b110: load_val = {32'd0, shifted[31:0]};
      default: load_val = shifted;
    endcase
`ifdef MISALIGN_TRAP_EN
    access_err = |(lat_addr[2:0] & width_m1);
`else
    access_err = 1'b0;
`endif
    access = (state == BUSY) && (cnt == 4'd0);
    // Reset on the access edge must suppress a pending store.
    mem_we = reset_n && access && lat_write && !access_err;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_size  <= req_size;
            lat_addr  <= req_addr[IDX_W+2:0];
            lat_wdata <= req_wdata;
            cnt       <= WAIT_STATES[3:0];
            req_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            resp_valid <= 1'b1;
            resp_err   <= access_err;
            resp_rdata <= (lat_write || access_err) ? 64'd0 : load_val;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder against a byte-array model
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_size = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_ready = 1'b0;
  logic        sel0 = 1'b0;

  logic        rr2, rv2, re2, rr0, rv0, re0;
  logic [63:0] rd2, rd0;
  logic        m_ready, m_valid, m_err;
  logic [63:0] m_rdata;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] mem_m [2048];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid & ~sel0), .req_ready(rr2),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv2), .resp_ready(resp_ready & ~sel0), .resp_rdata(rd2), .resp_err(re2));

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid & sel0), .req_ready(rr0),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_ready(resp_ready & sel0), .resp_rdata(rd0), .resp_err(re0));

  assign m_ready = sel0 ? rr0 : rr2;
  assign m_valid = sel0 ? rv0 : rv2;
  assign m_err   = sel0 ? re0 : re2;
  assign m_rdata = sel0 ? rd0 : rd2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic w, input logic [2:0] sz, input logic [63:0] a,
                                input logic [63:0] wd, output logic [63:0] rd, output logic er);
    int width = 1 << sz[1:0];
    int lane = int'(a[2:0]);
    int base = int'(a[10:3]) * 8;
    rd = 64'd0;
    er = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (lane % width != 0) begin
      er = 1'b1;
      return;
    end
`endif
    lane = lane - (lane % width);
    for (int i = 0; i < width; i++) begin
      if (w) mem_m[base + lane + i] = wd[8*i +: 8];
      else   rd[8*i +: 8] = mem_m[base + lane + i];
    end
    if (!w && !sz[2] && width < 8 && rd[8*width-1]) begin
      for (int i = width; i < 8; i++) rd[8*i +: 8] = 8'hFF;
    end
  endfunction

  task automatic xact(input logic w, input logic [2:0] sz, input logic [63:0] a, input logic [63:0] wd,
                      output logic [63:0] rd, output logic er, output int lat, output logic rdy_low);
    int guard = 0;
    @(negedge clk);
    req_write = w; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    while (!m_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_bound", guard < 50, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    rdy_low = 1'b1;
    while (!m_valid && lat < 64) begin
      if (m_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    rd = m_rdata;
    er = m_err;
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    check("resp_drop", m_valid, 1'b0);
  endtask

  task automatic run(input logic w, input logic [2:0] sz, input logic [63:0] a, input logic [63:0] wd,
                     output logic [63:0] rd);
    logic [63:0] exp_rd;
    logic exp_er, er, rl;
    int lat;
    model(w, sz, a, wd, exp_rd, exp_er);
    xact(w, sz, a, wd, rd, er, lat, rl);
    check("rdata", rd, exp_rd);
    check("err", er, exp_er);
    check("latency", lat, 3);
    check("ready_low", rl, 1'b1);
  endtask

  initial begin
    logic [63:0] rd, exp_rd, hold;
    logic er, exp_er, rl;
    int lat;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rv2, 1'b0);
    check("rst_rdata", rd2, 64'd0);
    check("rst_err", re2, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", rr2, 1'b1);

    for (int i = 0; i < 256; i++) run(1'b1, 3'b011, 64'(i * 8), 64'd0, rd);

    run(1'b1, 3'b011, 64'h10, 64'h1122334455667788, rd);
    run(1'b0, 3'b011, 64'h10, 64'd0, rd);
    check("t1_ld", rd, 64'h1122334455667788);
    run(1'b0, 3'b000, 64'h10, 64'd0, rd);  check("t2_lb", rd, 64'hFFFFFFFFFFFFFF88);
    run(1'b0, 3'b100, 64'h17, 64'd0, rd);  check("t2_lbu", rd, 64'h11);
    run(1'b0, 3'b001, 64'h16, 64'd0, rd);  check("t2_lh", rd, 64'h1122);
    run(1'b0, 3'b010, 64'h14, 64'd0, rd);  check("t2_lw", rd, 64'h11223344);
    run(1'b0, 3'b110, 64'h10, 64'd0, rd);  check("t2_lwu", rd, 64'h55667788);
    run(1'b1, 3'b000, 64'h13, 64'hAB, rd);
    run(1'b0, 3'b011, 64'h10, 64'd0, rd);  check("t3_ld", rd, 64'h11223344AB667788);
    run(1'b0, 3'b011, 64'h810, 64'd0, rd); check("t3_alias", rd, 64'h11223344AB667788);

    // Backpressure: hold response while a second request waits.
    model(1'b0, 3'b011, 64'h10, 64'd0, exp_rd, exp_er);
    @(negedge clk);
    req_write = 1'b0; req_size = 3'b011; req_addr = 64'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rv2 && lat < 64) begin @(posedge clk); #1; lat++; end
    check("t4_lat", lat, 3);
    hold = rd2;
    check("t4_rdata", hold, exp_rd);
    req_write = 1'b1; req_size = 3'b011; req_addr = 64'h30; req_wdata = 64'hCAFEF00D12345678;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("t4_valid", rv2, 1'b1);
      check("t4_hold", rd2, hold);
      check("t4_err", re2, 1'b0);
      check("t4_noaccept", rr2, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("t4_drop", rv2, 1'b0);
    check("t4_ready_after", rr2, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("t4_accepted", rr2, 1'b0);
    model(1'b1, 3'b011, 64'h30, 64'hCAFEF00D12345678, exp_rd, exp_er);
    lat = 0;
    while (!rv2 && lat < 64) begin @(posedge clk); #1; lat++; end
    check("t4_lat2", lat, 3);
    check("t4_st_rdata", rd2, 64'd0);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    run(1'b0, 3'b011, 64'h30, 64'd0, rd);
    check("t4_st_read", rd, 64'hCAFEF00D12345678);

    run(1'b1, 3'b011, 64'h10, 64'h1122334455667788, rd);
    run(1'b0, 3'b010, 64'h12, 64'd0, rd);
`ifdef MISALIGN_TRAP_EN
    check("t6_lw", rd, 64'd0);
`else
    check("t6_lw", rd, 64'h55667788);
`endif
    run(1'b1, 3'b010, 64'h12, 64'hFFFFFFFF, rd);
    run(1'b0, 3'b011, 64'h10, 64'd0, rd);
`ifdef MISALIGN_TRAP_EN
    check("t6_word", rd, 64'h1122334455667788);
`else
    check("t6_word", rd, 64'h11223344FFFFFFFF);
`endif

    for (int n = 0; n < 200; n++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[63:11] = '0;
      run(1'(($urandom_range(0, 1))), 3'($urandom_range(0, 7)), a, {$urandom, $urandom}, rd);
    end

    // Reset while a store is in BUSY.
    run(1'b1, 3'b011, 64'h20, 64'd0, rd);
    @(negedge clk);
    req_write = 1'b1; req_size = 3'b011; req_addr = 64'h20; req_wdata = 64'hDEAD; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("t5_valid", rv2, 1'b0);
    check("t5_rdata", rd2, 64'd0);
    check("t5_err", re2, 1'b0);
    check("t5_ready", rr2, 1'b1);
    reset_n = 1'b1;
    run(1'b0, 3'b011, 64'h20, 64'd0, rd);
    check("t5_ld", rd, 64'd0);

    sel0 = 1'b1;
    xact(1'b1, 3'b011, 64'h20, 64'd0, rd, er, lat, rl);
    check("t5w0_lat", lat, 1);
    @(negedge clk);
    req_write = 1'b1; req_size = 3'b011; req_addr = 64'h20; req_wdata = 64'hDEAD; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("t5w0_valid", rv0, 1'b0);
    check("t5w0_ready", rr0, 1'b1);
    reset_n = 1'b1;
    xact(1'b0, 3'b011, 64'h20, 64'd0, rd, er, lat, rl);
    check("t5w0_ld", rd, 64'd0);
    check("t5w0_lat2", lat, 1);
    xact(1'b1, 3'b001, 64'h22, 64'h8001, rd, er, lat, rl);
    xact(1'b0, 3'b001, 64'h22, 64'd0, rd, er, lat, rl);
    check("t5w0_lh", rd, 64'hFFFFFFFFFFFF8001);
    sel0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
